poly_basemul_ctrl: RTL and testbench
====================================

# poly_basemul_ctrl

Sequencer that drives the `basemul` unit across a full NTT-domain polynomial. It reads 128 coefficient pairs of â and b̂ from operand RAM, presents each pair with its zeta to `basemul`, and waits for the result handshake. It then writes r̂ back to the result RAM. It sits between the polynomial RAMs and `basemul` in the matrix-vector multiply path, acting as the initiator for `basemul`'s start/valid protocol.

## Interface
Parameters:
- `TIMEOUT`, default 15: maximum cycles spent waiting for `bm_r0_valid` before the block raises `err`.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `start`  in  1  one-cycle request to process a whole polynomial; ignored while `busy`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse after the 128th write.
- `err`  out  1  sticky timeout flag; cleared by the next accepted `start`.
- `rd_en`  out  1  operand RAM read strobe.
- `rd_addr`  out  7  pair index j, 0..127.
- `rd_a[2]`, `rd_b[2]`  in  `KYBER_POLY_WIDTH` each  coefficients 2j and 2j+1 of â and b̂; valid one cycle after `rd_en`.
- `bm_start`  out  1  drives `basemul_start`.
- `bm_a[2]`, `bm_b[2]`, `bm_zeta`  out  `KYBER_POLY_WIDTH`, signed  operands to `basemul`.
- `bm_r[2]`  in  `KYBER_POLY_WIDTH`, signed  `basemul` result.
- `bm_r0_valid`  in  1  `basemul` completion flag (level, not a pulse).
- `wr_en`  out  1  result RAM write strobe.
- `wr_addr`  out  7  pair index.
- `wr_data[2]`  out  `KYBER_POLY_WIDTH`  r̂ coefficients 2j and 2j+1.

## Operation
- States are IDLE, READ, LOAD, WAIT, WRITE, FIN.
- **IDLE.** On `start`: clear j and `err`, then go to READ.
- **READ.** Assert `rd_en` with `rd_addr`=j for one cycle, then go to LOAD.
- **LOAD.** Register `rd_a`/`rd_b` into `bm_a`/`bm_b`.
  - Set `bm_zeta` = ZETAS[64 + j>>1] when j is even, and its negation when j is odd. Negation is a 16-bit two's complement.
  - Assert `bm_start` for exactly one cycle, clear the wait counter, then go to WAIT.
- **WAIT.**
  - The first WAIT cycle is a guard: `bm_r0_valid` is ignored there, because the stale valid from the previous pair is cleared on that edge.
  - After the guard, when `bm_r0_valid`=1, capture `bm_r` into `wr_data` and go to WRITE.
  - The wait counter increments every WAIT cycle. If it reaches `TIMEOUT`, set `err` and go to FIN without writing.
- **WRITE.** Assert `wr_en` with `wr_addr`=j for one cycle.
  - If j==127, go to FIN.
  - Otherwise increment j and go to READ.
- **FIN.** Pulse `done` for one cycle, then go to IDLE.
- `bm_a`, `bm_b` and `bm_zeta` are held stable from LOAD until the next LOAD, because `basemul` re-samples `zeta` mid-computation.
- `start` is ignored outside IDLE.

## Timing
- Reset values: all outputs 0, state IDLE, j=0, `err`=0.
- Reset mid-operation returns to IDLE immediately. Partially written results are not rolled back.
- Per pair: 1 cycle READ + 1 cycle LOAD + W cycles WAIT + 1 cycle WRITE, where W is `basemul` latency + 1.
- Total: 128·(3+W) + 1 cycles from `start` to `done`.
- `busy` goes high the cycle after `start` and drops in the same cycle `done` pulses.
- If `start` and `done` occur in the same cycle, `start` is dropped.
- There is no back-pressure on the RAM ports: reads complete in one cycle and writes always succeed.

## Structure
- `kyber_pkg` holds the shared items:
  - `KYBER_Q` = 3329.
  - The 128-entry signed 16-bit `ZETAS` table in Montgomery form: ZETAS[64] = −1103, ZETAS[65] = 430, ZETAS[66] = 555.
  - The state enum for this block.
- `KYBER_POLY_WIDTH` comes from `params.vh`.
- Single module. `basemul` is instantiated by the parent, not inside this block, so the port boundary is the protocol under test.

## Test plan
1. **Reset.** Assert `rst_n`=0 mid-WAIT on pair 5 → all outputs 0 within the reset cycle. A new `start` afterwards begins at j=0.
2. **Zeta sequencing.** Full run with a behavioural `basemul` (fixed W=5) → `bm_zeta` over pairs 0..3 is −1103, 1103, 430, −430. Pair 127 uses −ZETAS[127].
3. **Arithmetic end-to-end.** Use the real `basemul` with â=b̂ = all 1 (Montgomery), then compare against the C reference `poly_basemul_montgomery` → all 128 `wr_data` pairs match. `done` arrives at cycle 128·(3+W)+1.
4. **Stale-valid guard.** Model holds `bm_r0_valid`=1 for the cycle after `bm_start` before clearing → no early `wr_en`. The write occurs only on the fresh valid.
5. **Timeout.** Model never asserts valid on pair 2 → `err`=1 after `TIMEOUT` WAIT cycles and `done` pulses. Only pairs 0..1 are written. A subsequent `start` clears `err`.
6. **Start while busy.** Pulse `start` at pair 40 → ignored, with no restart of j and no extra `done`.

Source files
------------

// File: rtl/poly_basemul_ctrl_pkg.sv
// Shared Kyber constants, the Montgomery-form zeta table and the sequencer state type
// for the polynomial base-multiplication controller.
package poly_basemul_ctrl_pkg;

    localparam int KYBER_POLY_WIDTH = 16;
    localparam int KYBER_Q          = 3329;

    localparam logic signed [KYBER_POLY_WIDTH-1:0] ZETAS [128] = '{
        -16'sd1044,  -16'sd758,  -16'sd359, -16'sd1517,  16'sd1493,  16'sd1422,   16'sd287,   16'sd202,
         -16'sd171,   16'sd622,  16'sd1577,   16'sd182,   16'sd962, -16'sd1202, -16'sd1474,  16'sd1468,
          16'sd573, -16'sd1325,   16'sd264,   16'sd383,  -16'sd829,  16'sd1458, -16'sd1602,  -16'sd130,
         -16'sd681,  16'sd1017,   16'sd732,   16'sd608, -16'sd1542,   16'sd411,  -16'sd205, -16'sd1571,
         16'sd1223,   16'sd652,  -16'sd552,  16'sd1015, -16'sd1293,  16'sd1491,  -16'sd282, -16'sd1544,
          16'sd516,    -16'sd8,  -16'sd320,  -16'sd666, -16'sd1618, -16'sd1162,   16'sd126,  16'sd1469,
         -16'sd853,   -16'sd90,  -16'sd271,   16'sd830,   16'sd107, -16'sd1421,  -16'sd247,  -16'sd951,
         -16'sd398,   16'sd961, -16'sd1508,  -16'sd725,   16'sd448, -16'sd1065,   16'sd677, -16'sd1275,
        -16'sd1103,   16'sd430,   16'sd555,   16'sd843, -16'sd1251,   16'sd871,  16'sd1550,   16'sd105,
          16'sd422,   16'sd587,   16'sd177,  -16'sd235,  -16'sd291,  -16'sd460,  16'sd1574,  16'sd1653,
         -16'sd246,   16'sd778,  16'sd1159,  -16'sd147,  -16'sd777,  16'sd1483,  -16'sd602,  16'sd1119,
        -16'sd1590,   16'sd644,  -16'sd872,   16'sd349,   16'sd418,   16'sd329,  -16'sd156,   -16'sd75,
          16'sd817,  16'sd1097,   16'sd603,   16'sd610,  16'sd1322, -16'sd1285, -16'sd1465,   16'sd384,
        -16'sd1215,  -16'sd136,  16'sd1218, -16'sd1335,  -16'sd874,   16'sd220, -16'sd1187, -16'sd1659,
        -16'sd1185, -16'sd1530, -16'sd1278,   16'sd794, -16'sd1510,  -16'sd854,  -16'sd870,   16'sd478,
         -16'sd108,  -16'sd308,   16'sd996,   16'sd991,   16'sd958, -16'sd1460,  16'sd1522,  16'sd1628
    };

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LOAD  = 3'd2,
        S_WAIT  = 3'd3,
        S_WRITE = 3'd4,
        S_FIN   = 3'd5
    } pbm_state_e;

    // Pair j uses ZETAS[64 + j/2]; odd pairs take the 16-bit two's-complement negation.
    function automatic logic signed [KYBER_POLY_WIDTH-1:0] zeta_for(input logic [6:0] j);
        logic signed [KYBER_POLY_WIDTH-1:0] z;
        z = ZETAS[{1'b1, j[6:1]}];
        return j[0] ? -z : z;
    endfunction

endpackage

// File: rtl/poly_basemul_ctrl_if.sv
// Bundle of the control, operand-RAM, basemul and result-RAM signals of the
// polynomial base-multiplication sequencer.
interface poly_basemul_ctrl_if;
    import poly_basemul_ctrl_pkg::*;

    logic                               start;
    logic                               busy;
    logic                               done;
    logic                               err;

    logic                               rd_en;
    logic [6:0]                         rd_addr;
    logic [KYBER_POLY_WIDTH-1:0]        rd_a [2];
    logic [KYBER_POLY_WIDTH-1:0]        rd_b [2];

    logic                               bm_start;
    logic signed [KYBER_POLY_WIDTH-1:0] bm_a [2];
    logic signed [KYBER_POLY_WIDTH-1:0] bm_b [2];
    logic signed [KYBER_POLY_WIDTH-1:0] bm_zeta;
    logic signed [KYBER_POLY_WIDTH-1:0] bm_r [2];
    logic                               bm_r0_valid;

    logic                               wr_en;
    logic [6:0]                         wr_addr;
    logic [KYBER_POLY_WIDTH-1:0]        wr_data [2];

    modport master (
        input  start, rd_a, rd_b, bm_r, bm_r0_valid,
        output busy, done, err, rd_en, rd_addr, bm_start, bm_a, bm_b, bm_zeta,
               wr_en, wr_addr, wr_data
    );

    modport slave (
        output start, rd_a, rd_b, bm_r, bm_r0_valid,
        input  busy, done, err, rd_en, rd_addr, bm_start, bm_a, bm_b, bm_zeta,
               wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/poly_basemul_ctrl.sv
// Walks the 128 coefficient pairs of a polynomial: read operands, launch basemul with the
// pair's zeta, wait for its result, write it back; flags a timeout if basemul stalls.
module poly_basemul_ctrl
    import poly_basemul_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    poly_basemul_ctrl_if.master bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    pbm_state_e r_state;
    pbm_state_e w_next;

    logic [6:0]                         r_j;
    logic [CNT_W-1:0]                   r_wcnt;
    logic [CNT_W-1:0]                   w_wcnt_nxt;
    logic                               r_err;
    logic                               r_bm_start;
    logic signed [KYBER_POLY_WIDTH-1:0] r_bm_a [2];
    logic signed [KYBER_POLY_WIDTH-1:0] r_bm_b [2];
    logic signed [KYBER_POLY_WIDTH-1:0] r_bm_zeta;
    logic [KYBER_POLY_WIDTH-1:0]        r_wr_data [2];

    logic w_wait_valid;
    logic w_wait_expire;
    logic w_rd_en;
    logic w_wr_en;
    logic w_busy;
    logic w_done;

    // The first WAIT cycle (counter still 0) ignores the previous pair's level-valid.
    assign w_wcnt_nxt    = r_wcnt + 1'b1;
    assign w_wait_valid  = (r_wcnt != '0) && bus.bm_r0_valid;
    assign w_wait_expire = (w_wcnt_nxt == CNT_W'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_READ;
            S_READ:  w_next = S_LOAD;
            S_LOAD:  w_next = S_WAIT;
            S_WAIT: begin
                if (w_wait_valid) begin
                    w_next = S_WRITE;
                end else if (w_wait_expire) begin
                    w_next = S_FIN;
                end
            end
            S_WRITE: w_next = (r_j == 7'd127) ? S_FIN : S_READ;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_rd_en = (r_state == S_READ);
        w_wr_en = (r_state == S_WRITE);
        w_done  = (r_state == S_FIN);
        w_busy  = (r_state != S_IDLE) && (r_state != S_FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_j        <= '0;
            r_wcnt     <= '0;
            r_err      <= 1'b0;
            r_bm_start <= 1'b0;
            r_bm_a     <= '{default: '0};
            r_bm_b     <= '{default: '0};
            r_bm_zeta  <= '0;
            r_wr_data  <= '{default: '0};
        end else begin
            r_bm_start <= (r_state == S_LOAD);
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_j   <= '0;
                        r_err <= 1'b0;
                    end
                end
                // Operands and zeta stay put until the next LOAD; basemul re-reads zeta late.
                S_LOAD: begin
                    r_bm_a[0] <= $signed(bus.rd_a[0]);
                    r_bm_a[1] <= $signed(bus.rd_a[1]);
                    r_bm_b[0] <= $signed(bus.rd_b[0]);
                    r_bm_b[1] <= $signed(bus.rd_b[1]);
                    r_bm_zeta <= zeta_for(r_j);
                    r_wcnt    <= '0;
                end
                S_WAIT: begin
                    r_wcnt <= w_wcnt_nxt;
                    if (w_wait_valid) begin
                        r_wr_data[0] <= $unsigned(bus.bm_r[0]);
                        r_wr_data[1] <= $unsigned(bus.bm_r[1]);
                    end else if (w_wait_expire) begin
                        r_err <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (r_j != 7'd127) r_j <= r_j + 7'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign bus.err        = r_err;
    assign bus.rd_en      = w_rd_en;
    assign bus.rd_addr    = r_j;
    assign bus.bm_start   = r_bm_start;
    assign bus.bm_a[0]    = r_bm_a[0];
    assign bus.bm_a[1]    = r_bm_a[1];
    assign bus.bm_b[0]    = r_bm_b[0];
    assign bus.bm_b[1]    = r_bm_b[1];
    assign bus.bm_zeta    = r_bm_zeta;
    assign bus.wr_en      = w_wr_en;
    assign bus.wr_addr    = r_j;
    assign bus.wr_data[0] = r_wr_data[0];
    assign bus.wr_data[1] = r_wr_data[1];

endmodule

// File: tb/tb_poly_basemul_ctrl.sv
// Bench for poly_basemul_ctrl: operand RAM and a behavioural basemul around the DUT,
// with a per-cycle timeline model derived from the pair/phase arithmetic of a run.
module tb_poly_basemul_ctrl;
    import poly_basemul_ctrl_pkg::*;

    localparam int TOUT = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    poly_basemul_ctrl_if bus();

    poly_basemul_ctrl #(.TIMEOUT(TOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int      total = 0;
    int      bad   = 0;
    int      cyc   = 0;
    int      W     = 5;
    int      fail_pair = -1;
    shortint memA [256];
    shortint memB [256];

    // model / run parameters (written by the driver, read by the checker)
    bit mdl_on   = 1'b0;
    int s0       = 0;
    int run_W    = 5;
    int run_fail = -1;
    int pin_done = -1;
    int pin_wr   = -1;
    bit pin_z    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference arithmetic (Kyber C reference) ----------------
    function automatic shortint mred(input int a);
        int t;
        t = int'(shortint'(a)) * -3327;
        t = int'(shortint'(t));
        return shortint'((a - t * KYBER_Q) >>> 16);
    endfunction

    function automatic shortint fqmul(input shortint a, input shortint b);
        return mred(int'(a) * int'(b));
    endfunction

    function automatic void bref(input shortint a0, input shortint a1, input shortint b0,
                                 input shortint b1, input shortint z,
                                 output shortint r0, output shortint r1);
        shortint t;
        t  = fqmul(a1, b1);
        t  = fqmul(t, z);
        r0 = shortint'(t + fqmul(a0, b0));
        r1 = shortint'(fqmul(a0, b1) + fqmul(a1, b0));
    endfunction

    function automatic shortint zexp(input int p);
        shortint z;
        z = shortint'(ZETAS[7'(64 + p / 2)]);
        return (p % 2 == 1) ? shortint'(-z) : z;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc - s0);
        end
    endtask

    // ---------------- operand RAM: one-cycle read latency ----------------
    logic [6:0] rd_pair = '0;
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.rd_a[0] <= memA[{bus.rd_addr, 1'b0}];
            bus.rd_a[1] <= memA[{bus.rd_addr, 1'b1}];
            bus.rd_b[0] <= memB[{bus.rd_addr, 1'b0}];
            bus.rd_b[1] <= memB[{bus.rd_addr, 1'b1}];
            rd_pair     <= bus.rd_addr;
        end
    end

    // ---------------- behavioural basemul: level valid in WAIT cycle W ----------------
    int      bm_cnt;
    bit      bm_ok;
    shortint res0, res1;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bm_cnt <= 0;
            bm_ok  <= 1'b0;
        end else if (bus.bm_start) begin
            shortint r0, r1;
            bref(shortint'(bus.bm_a[0]), shortint'(bus.bm_a[1]), shortint'(bus.bm_b[0]),
                 shortint'(bus.bm_b[1]), shortint'(bus.bm_zeta), r0, r1);
            res0   <= r0;
            res1   <= r1;
            bm_cnt <= 1;
            bm_ok  <= (int'(rd_pair) != fail_pair);
        end else if (bm_cnt > 0 && bm_cnt < 100000) begin
            bm_cnt <= bm_cnt + 1;
        end
    end
    assign bus.bm_r[0]     = res0;
    assign bus.bm_r[1]     = res1;
    assign bus.bm_r0_valid = bm_ok && (bm_cnt >= W - 1);

    // ---------------- checker ----------------
    int nwr   = 0;
    int ndone = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_busy",     int'(bus.busy),     0);
            chk("rst_done",     int'(bus.done),     0);
            chk("rst_err",      int'(bus.err),      0);
            chk("rst_rd_en",    int'(bus.rd_en),    0);
            chk("rst_rd_addr",  int'(bus.rd_addr),  0);
            chk("rst_bm_start", int'(bus.bm_start), 0);
            chk("rst_bm_zeta",  int'(bus.bm_zeta),  0);
            chk("rst_bm_a0",    int'(bus.bm_a[0]),  0);
            chk("rst_bm_b1",    int'(bus.bm_b[1]),  0);
            chk("rst_wr_en",    int'(bus.wr_en),    0);
            chk("rst_wr_addr",  int'(bus.wr_addr),  0);
            chk("rst_wr_data0", int'(bus.wr_data[0]), 0);
        end else if (mdl_on && (cyc - s0) >= 1) begin
            int c, L, p, ph, endc, nexp, zl;
            bit e_busy, e_rd, e_bs, e_wr, e_done, e_err;
            shortint r0, r1;
            c    = cyc - s0;
            L    = run_W + 3;
            endc = (run_fail < 0) ? 128 * L + 1 : run_fail * L + TOUT + 3;
            if (c == 1) begin
                nwr   = 0;
                ndone = 0;
            end
            if (run_fail >= 0 && c > run_fail * L) begin
                p  = run_fail;
                ph = c - 1 - run_fail * L;
            end else begin
                p  = (c - 1) / L;
                ph = (c - 1) % L;
            end
            e_done = (c == endc);
            e_busy = (c < endc);
            e_rd   = e_busy && ph == 0;
            e_bs   = e_busy && ph == 2;
            e_wr   = e_busy && p != run_fail && ph == run_W + 2;
            e_err  = (c >= endc) && run_fail >= 0;

            chk("busy",     int'(bus.busy),     int'(e_busy));
            chk("done",     int'(bus.done),     int'(e_done));
            chk("err",      int'(bus.err),      int'(e_err));
            chk("rd_en",    int'(bus.rd_en),    int'(e_rd));
            chk("bm_start", int'(bus.bm_start), int'(e_bs));
            chk("wr_en",    int'(bus.wr_en),    int'(e_wr));
            if (e_rd) chk("rd_addr", int'(bus.rd_addr), p);
            if (e_busy && ph >= 2) chk("bm_zeta_hold", int'(bus.bm_zeta), int'(zexp(p)));
            if (e_bs) begin
                chk("bm_a0", int'(bus.bm_a[0]), int'(memA[8'(2 * p)]));
                chk("bm_a1", int'(bus.bm_a[1]), int'(memA[8'(2 * p + 1)]));
                chk("bm_b0", int'(bus.bm_b[0]), int'(memB[8'(2 * p)]));
                chk("bm_b1", int'(bus.bm_b[1]), int'(memB[8'(2 * p + 1)]));
                if (pin_z && (p <= 3 || p == 127)) begin
                    case (p)
                        0:       zl = -1103;
                        1:       zl = 1103;
                        2:       zl = 430;
                        3:       zl = -430;
                        default: zl = -1628;
                    endcase
                    chk("zeta_pin", int'(bus.bm_zeta), zl);
                end
            end
            if (e_wr) begin
                bref(memA[8'(2 * p)], memA[8'(2 * p + 1)], memB[8'(2 * p)], memB[8'(2 * p + 1)],
                     zexp(p), r0, r1);
                chk("wr_addr",  int'(bus.wr_addr), p);
                chk("wr_data0", int'($signed(bus.wr_data[0])), int'(r0));
                chk("wr_data1", int'($signed(bus.wr_data[1])), int'(r1));
            end
            if (bus.wr_en) nwr++;
            if (bus.done) begin
                ndone++;
                if (pin_done > 0) chk("done_cycle", c, pin_done);
            end
            if (c == endc + 1) begin
                nexp = (pin_wr >= 0) ? pin_wr : ((run_fail < 0) ? 128 : run_fail);
                chk("write_count", nwr, nexp);
                chk("done_count", ndone, 1);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic run(input int w, input int fail, input int pat, input int sp,
                       input int abort_k, input int pdone, input int pwr, input bit pz);
        int endc;
        @(posedge clk);
        #2;
        for (int i = 0; i < 256; i++) begin
            if (pat == 0) begin
                memA[i] = 16'sd2285;
                memB[i] = 16'sd2285;
            end else begin
                memA[i] = shortint'((i * 37 + pat * 101 + 5) % 3329);
                memB[i] = shortint'((i * 53 + pat * 7) % 3329 - 1664);
            end
        end
        W         = w;
        fail_pair = fail;
        run_W     = w;
        run_fail  = fail;
        pin_done  = pdone;
        pin_wr    = pwr;
        pin_z     = pz;
        s0        = cyc;
        mdl_on    = 1'b1;
        bus.start = 1'b1;
        endc = (fail < 0) ? 128 * (w + 3) + 1 : fail * (w + 3) + TOUT + 3;
        for (int k = 1; k <= endc + 4; k++) begin
            @(posedge clk);
            #2;
            if (k == abort_k) begin
                bus.start = 1'b0;
                rst_n     = 1'b0;
                mdl_on    = 1'b0;
                repeat (2) @(posedge clk);
                #2;
                rst_n = 1'b1;
                break;
            end
            bus.start = (k == sp);
        end
        bus.start = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        // W=5 full run, zeta pins, done latency pin, stray start at pair 40
        run(5, -1, 0, 40 * 8 + 3, -1, 1025, 128, 1'b1);
        // shortest basemul latency
        run(2, -1, 1, -1, -1, 128 * 5 + 1, -1, 1'b0);
        // valid arrives on the very last permitted WAIT cycle
        run(TOUT, -1, 2, -1, -1, 128 * (TOUT + 3) + 1, -1, 1'b0);
        // basemul stalls on pair 2
        run(5, 2, 3, -1, -1, 34, 2, 1'b0);
        // reset mid-WAIT on pair 5 (start also clears the sticky err)
        run(5, -1, 4, -1, 5 * 8 + 5, -1, -1, 1'b0);
        // fresh run after the reset starts from pair 0
        run(3, -1, 5, -1, -1, 128 * 6 + 1, -1, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
